pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 64, max data-memory wait cycles before abort; legal range 2..255.
REQ-002 Parameter REG_W, default 5, register-index width.
REQ-003 clk_i  in  1  single clock, rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-low.
REQ-005 IDEX_MemRead_i  in  1  instruction in EX is a load.
REQ-006 IDEX_Rd_i  in  REG_W  destination of instruction in EX.
REQ-007 IFID_Rs1_i, IFID_Rs2_i  in  REG_W each  sources of instruction in ID.
REQ-008 Branch_i  in  1  branch resolved taken in ID.
REQ-009 mem_req_i  in  1  instruction in MEM accesses data memory.
REQ-010 mem_ack_i  in  1  data memory completes the access this cycle.
REQ-011 PCWrite_o  out  1  PC update enable.
REQ-012 Stall_o  out  1  IF/ID hold, load-use.
REQ-013 MemStall_o  out  1  global freeze, memory wait.
REQ-014 Flush_o  out  1  IF/ID zero on next edge.
REQ-015 Bubble_o  out  1  ID/EX control zeroed.
REQ-016 err_o  out  1  sticky memory-timeout flag.
REQ-017 stall_cnt_o  out  16  saturating count of stalled cycles.

Function
REQ-018 hazard = IDEX_MemRead_i & (IDEX_Rd_i != 0) & (IDEX_Rd_i == IFID_Rs1_i | IDEX_Rd_i == IFID_Rs2_i), combinational.
REQ-019 Memory FSM states: IDLE, WAIT, DONE; encoding from shared package.
REQ-020 IDLE: mem_req_i=1 -> WAIT; else stay.
REQ-021 WAIT: mem_ack_i=1 -> DONE; wait counter reaching MEM_TIMEOUT-1 without ack -> DONE and set err_o.
REQ-022 DONE: unconditional -> IDLE after exactly one cycle; mem_req_i ignored in DONE.
REQ-023 MemStall_o = (IDLE & mem_req_i) | (WAIT & ~mem_ack_i & ~timeout), combinational, zero-cycle latency.
REQ-024 Wait counter, 8 bits, clears on entry to WAIT, increments each WAIT cycle.
REQ-025 Stall_o = hazard & ~MemStall_o.
REQ-026 Bubble_o = Stall_o.
REQ-027 Flush_o = Branch_i & ~hazard & ~MemStall_o; stall wins over flush, branch re-evaluated after stall.
REQ-028 PCWrite_o = ~(Stall_o | MemStall_o); taken branch still writes PC.
REQ-029 MemStall_o dominates: simultaneous hazard, branch and memory wait -> only MemStall_o=1.
REQ-030 stall_cnt_o increments on each cycle with Stall_o|MemStall_o, saturates at 16'hFFFF.
REQ-031 err_o, once set, stays 1 until reset.
REQ-032 mem_ack_i in IDLE or DONE ignored.

Reset
REQ-033 rst_i=0 at rising edge: FSM IDLE, wait counter 0, stall_cnt_o 0, err_o 0.
REQ-034 Reset mid-WAIT aborts wait; MemStall_o follows REQ-023 from IDLE in the same cycle.
REQ-035 Registered state only; all other outputs combinational from inputs and state.

Structure
REQ-036 FSM state typedef/localparams and default MEM_TIMEOUT in shared pipeline package.
REQ-037 One sub-module natural: mem_wait_fsm (states, wait counter, timeout, err_o); hazard/flush logic stays top-level.

Verification
REQ-038 Load x5 in EX, ID reads x5 -> Stall_o=1, Bubble_o=1, PCWrite_o=0 one cycle; Rd=x0 -> no stall.
REQ-039 Branch_i=1, no hazard -> Flush_o=1, PCWrite_o=1; with hazard -> Flush_o=0, Stall_o=1.
REQ-040 mem_req_i=1, ack after 3 cycles -> MemStall_o=1 for 3 cycles, 0 on ack cycle, DONE one cycle, stall_cnt_o=3.
REQ-041 mem_req_i held, no ack, MEM_TIMEOUT=4 -> MemStall_o=1 4 cycles, err_o=1 thereafter, DONE then IDLE.
REQ-042 Load-use hazard plus memory wait plus branch simultaneously -> only MemStall_o=1; rst_i=0 mid-WAIT -> state IDLE, counters 0, err_o 0.
REQ-043 Stall held 65540 cycles -> stall_cnt_o stays 16'hFFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline control definitions: memory-wait FSM encoding and defaults.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_WAIT = 2'd1,
    MS_DONE = 2'd2
  } mem_state_e;

  localparam int DEF_MEM_TIMEOUT = 64;
  localparam int WAIT_CNT_W      = 8;
  localparam int STALL_CNT_W     = 16;

endpackage

// File: rtl/pipe_hazard_ctrl_mem_wait_fsm.sv
// Data-memory wait tracker: freezes the pipe until ack or timeout, flags timeouts stickily.
module pipe_hazard_ctrl_mem_wait_fsm
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic mem_req_i,
  input  logic mem_ack_i,
  output logic mem_stall_o,
  output logic err_o
);

  localparam logic [WAIT_CNT_W-1:0] TMO_LAST = WAIT_CNT_W'(MEM_TIMEOUT - 1);

  mem_state_e              state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    set_err;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= MS_IDLE;
      cnt_q   <= '0;
      err_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_o   <= err_o | set_err;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    set_err     = 1'b0;
    mem_stall_o = 1'b0;
    case (state_q)
      MS_IDLE: if (mem_req_i) begin
        state_d     = MS_WAIT;
        cnt_d       = '0;
        mem_stall_o = 1'b1;
      end
      MS_WAIT: begin
        // ack wins over timeout when both land on the same cycle
        if (mem_ack_i) begin
          state_d = MS_DONE;
        end else if (cnt_q == TMO_LAST) begin
          state_d = MS_DONE;
          set_err = 1'b1;
        end else begin
          mem_stall_o = 1'b1;
          cnt_d       = cnt_q + 1'b1;
        end
      end
      MS_DONE: state_d = MS_IDLE;
      default: state_d = MS_IDLE;
    endcase
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control: load-use stall, branch flush, memory-wait freeze, stall counter.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = pipe_hazard_ctrl_pkg::DEF_MEM_TIMEOUT,
  parameter int REG_W       = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             IDEX_MemRead_i,
  input  logic [REG_W-1:0] IDEX_Rd_i,
  input  logic [REG_W-1:0] IFID_Rs1_i,
  input  logic [REG_W-1:0] IFID_Rs2_i,
  input  logic             Branch_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             PCWrite_o,
  output logic             Stall_o,
  output logic             MemStall_o,
  output logic             Flush_o,
  output logic             Bubble_o,
  output logic             err_o,
  output logic [15:0]      stall_cnt_o
);
  import pipe_hazard_ctrl_pkg::*;

  logic hazard;

  pipe_hazard_ctrl_mem_wait_fsm #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wait_fsm (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .mem_req_i   (mem_req_i),
    .mem_ack_i   (mem_ack_i),
    .mem_stall_o (MemStall_o),
    .err_o       (err_o)
  );

  assign hazard = IDEX_MemRead_i && (IDEX_Rd_i != '0) &&
                  ((IDEX_Rd_i == IFID_Rs1_i) || (IDEX_Rd_i == IFID_Rs2_i));

  // Memory freeze dominates; a stalled branch is re-evaluated once the load retires.
  assign Stall_o   = hazard & ~MemStall_o;
  assign Bubble_o  = Stall_o;
  assign Flush_o   = Branch_i & ~hazard & ~MemStall_o;
  assign PCWrite_o = ~(Stall_o | MemStall_o);

  always_ff @(posedge clk_i) begin
    if (!rst_i)
      stall_cnt_o <= '0;
    else if ((Stall_o || MemStall_o) && (stall_cnt_o != {STALL_CNT_W{1'b1}}))
      stall_cnt_o <= stall_cnt_o + 16'd1;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl with a short memory timeout.
module tb_pipe_hazard_ctrl;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        IDEX_MemRead_i;
  logic [4:0]  IDEX_Rd_i, IFID_Rs1_i, IFID_Rs2_i;
  logic        Branch_i, mem_req_i, mem_ack_i;
  logic        PCWrite_o, Stall_o, MemStall_o, Flush_o, Bubble_o, err_o;
  logic [15:0] stall_cnt_o;

  // flag vector order: {PCWrite, Stall, MemStall, Flush, Bubble, err}
  localparam logic [5:0] F_RUN   = 6'b100000;
  localparam logic [5:0] F_STALL = 6'b010010;
  localparam logic [5:0] F_MEM   = 6'b001000;
  localparam logic [5:0] F_FLUSH = 6'b100100;
  localparam logic [5:0] F_ERR   = 6'b000001;

  typedef struct {
    string       tag;
    logic [5:0]  flags;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] exp_cnt = '0;
  int          chk_cnt  = 0;
  int          pass_cnt = 0;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .REG_W(5)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .IDEX_MemRead_i (IDEX_MemRead_i),
    .IDEX_Rd_i      (IDEX_Rd_i),
    .IFID_Rs1_i     (IFID_Rs1_i),
    .IFID_Rs2_i     (IFID_Rs2_i),
    .Branch_i       (Branch_i),
    .mem_req_i      (mem_req_i),
    .mem_ack_i      (mem_ack_i),
    .PCWrite_o      (PCWrite_o),
    .Stall_o        (Stall_o),
    .MemStall_o     (MemStall_o),
    .Flush_o        (Flush_o),
    .Bubble_o       (Bubble_o),
    .err_o          (err_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic mr, input logic [4:0] rd, rs1, rs2,
                       input logic br, req, ack);
    IDEX_MemRead_i = mr;
    IDEX_Rd_i      = rd;
    IFID_Rs1_i     = rs1;
    IFID_Rs2_i     = rs2;
    Branch_i       = br;
    mem_req_i      = req;
    mem_ack_i      = ack;
  endtask

  task automatic check_head();
    exp_t       e;
    logic [5:0] obs;
    e   = sb.pop_front();
    obs = {PCWrite_o, Stall_o, MemStall_o, Flush_o, Bubble_o, err_o};
    chk_cnt++;
    assert (obs === e.flags) pass_cnt++;
    else $error("FAIL %s flags observed=%b expected=%b", e.tag, obs, e.flags);
    chk_cnt++;
    assert (stall_cnt_o === e.cnt) pass_cnt++;
    else $error("FAIL %s stall_cnt observed=%0d expected=%0d", e.tag, stall_cnt_o, e.cnt);
  endtask

  task automatic bump_cnt(input logic stalled);
    if (stalled && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
  endtask

  // One cycle: drive at negedge, check combinational/registered outputs, then clock.
  task automatic step(input string tag, input logic mr, input logic [4:0] rd, rs1, rs2,
                      input logic br, req, ack, input logic [5:0] ef);
    @(negedge clk);
    drive(mr, rd, rs1, rs2, br, req, ack);
    sb.push_back('{tag, ef, exp_cnt});
    #1;
    check_head();
    @(posedge clk);
    bump_cnt(ef[4] | ef[3]);
  endtask

  task automatic do_reset(input logic req);
    @(negedge clk);
    rst_i = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, req, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_i = 1'b1;
    exp_cnt = '0;
  endtask

  initial begin
    rst_i = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    do_reset(1'b0);

    step("reset_idle",    0, 5'd0, 5'd0, 5'd0, 0, 0, 0, F_RUN);
    step("loaduse_rs1",   1, 5'd5, 5'd5, 5'd1, 0, 0, 0, F_STALL);
    step("loaduse_rs2",   1, 5'd5, 5'd2, 5'd5, 0, 0, 0, F_STALL);
    step("rd_x0",         1, 5'd0, 5'd0, 5'd0, 0, 0, 0, F_RUN);
    step("no_memread",    0, 5'd5, 5'd5, 5'd5, 0, 0, 0, F_RUN);
    step("rd_mismatch",   1, 5'd5, 5'd6, 5'd7, 0, 0, 0, F_RUN);
    step("branch_flush",  0, 5'd0, 5'd1, 5'd2, 1, 0, 0, F_FLUSH);
    step("branch_hazard", 1, 5'd9, 5'd9, 5'd2, 1, 0, 0, F_STALL);
    step("branch_reeval", 0, 5'd9, 5'd9, 5'd2, 1, 0, 0, F_FLUSH);

    // ack after three stalled cycles
    step("mem_req",       0, 5'd0, 5'd0, 5'd0, 0, 1, 0, F_MEM);
    step("mem_wait0",     0, 5'd0, 5'd0, 5'd0, 0, 1, 0, F_MEM);
    step("mem_wait1",     0, 5'd0, 5'd0, 5'd0, 0, 1, 0, F_MEM);
    step("mem_ack",       0, 5'd0, 5'd0, 5'd0, 0, 1, 1, F_RUN);
    step("mem_done",      0, 5'd0, 5'd0, 5'd0, 0, 1, 1, F_RUN);
    step("idle_ack_ign",  0, 5'd0, 5'd0, 5'd0, 0, 0, 1, F_RUN);

    // no ack: timeout after MEM_TIMEOUT stalled cycles
    step("tmo_req",       0, 5'd0, 5'd0, 5'd0, 0, 1, 0, F_MEM);
    step("tmo_wait0",     0, 5'd0, 5'd0, 5'd0, 0, 1, 0, F_MEM);
    step("tmo_wait1",     0, 5'd0, 5'd0, 5'd0, 0, 1, 0, F_MEM);
    step("tmo_wait2",     0, 5'd0, 5'd0, 5'd0, 0, 1, 0, F_MEM);
    step("tmo_release",   0, 5'd0, 5'd0, 5'd0, 0, 1, 0, F_RUN);
    step("tmo_done_err",  0, 5'd0, 5'd0, 5'd0, 0, 1, 0, F_RUN | F_ERR);
    step("err_sticky",    0, 5'd0, 5'd0, 5'd0, 0, 0, 0, F_RUN | F_ERR);

    // memory freeze dominates hazard and branch
    step("all_idle_req",  1, 5'd5, 5'd5, 5'd0, 1, 1, 0, F_MEM | F_ERR);
    step("all_wait",      1, 5'd5, 5'd5, 5'd0, 1, 1, 0, F_MEM | F_ERR);

    // reset while in WAIT
    do_reset(1'b1);
    step("rst_idle",      0, 5'd0, 5'd0, 5'd0, 0, 0, 0, F_RUN);
    step("rst_req",       0, 5'd0, 5'd0, 5'd0, 0, 1, 0, F_MEM);
    step("rst_wait0",     0, 5'd0, 5'd0, 5'd0, 0, 1, 0, F_MEM);
    step("rst_wait1",     0, 5'd0, 5'd0, 5'd0, 0, 1, 0, F_MEM);
    step("rst_wait2",     0, 5'd0, 5'd0, 5'd0, 0, 1, 0, F_MEM);
    step("rst_tmo",       0, 5'd0, 5'd0, 5'd0, 0, 0, 0, F_RUN);
    step("rst_err_set",   0, 5'd0, 5'd0, 5'd0, 0, 0, 0, F_RUN | F_ERR);

    // stall counter saturation
    do_reset(1'b0);
    step("sat_start",     1, 5'd3, 5'd3, 5'd0, 0, 0, 0, F_STALL);
    repeat (65540) begin
      @(posedge clk);
      bump_cnt(1'b1);
    end
    step("sat_hold",      1, 5'd3, 5'd3, 5'd0, 0, 0, 0, F_STALL);
    step("sat_still",     1, 5'd3, 5'd0, 5'd3, 0, 0, 0, F_STALL);
    chk_cnt++;
    assert (stall_cnt_o === 16'hFFFF) pass_cnt++;
    else $error("FAIL sat_final stall_cnt observed=%h expected=ffff", stall_cnt_o);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
